sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO. It is the same-clock-domain successor to the dual-clock FIFO and is used wherever producer and consumer share one clock. Compared with the dual-clock block it adds configurable data width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow and underflow error flags. Flags are exact and registered; no synchronizers are needed.

---
 rtl/sync_fifo_prog.sv | 83 ++++++++
 tb/tb_sync_fifo_prog.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_prog #(
  parameter int DW        = 4,
  parameter int AW        = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          winc,
  input  logic [DW-1:0] wdata,
  input  logic          rinc,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AEMPTY_TH);

  if (AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_th
    $error("sync_fifo_prog: need 0 <= AEMPTY_TH < AFULL_TH <= 2**AW");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr, nwptr, nrptr, ncount;
  logic          wr_ok, rd_ok;

  assign wr_ok  = winc & ~full;
  assign rd_ok  = rinc & ~empty;
  assign nwptr  = wptr + (AW+1)'(wr_ok);
  assign nrptr  = rptr + (AW+1)'(rd_ok);
  // Wrap bit makes the modulo difference span 0..DEPTH exactly.
  assign ncount = nwptr - nrptr;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  // Flags come from next-state pointers so they are exact one edge later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= nwptr;
      rptr         <= nrptr;
      count        <= ncount;
      full         <= (ncount == DEPTH_C);
      empty        <= (ncount == '0);
      almost_full  <= (ncount >= AF_C);
      almost_empty <= (ncount <= AE_C);
      overflow     <= (winc & full)  | (overflow  & ~clr_err);
      underflow    <= (rinc & empty) | (underflow & ~clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[rptr[AW-1:0]];
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rdata <= '0;
    else if (rd_ok) rdata <= mem[rptr[AW-1:0]];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a queue scoreboard holds written words,
// a small occupancy/error-flag model predicts count and flags every cycle.
module tb_sync_fifo_prog;
  localparam int DW = 4, AW = 4, DEPTH = 16, AF = 14, AE = 2;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wdata = '0, rdata;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int checks = 0, errors = 0;
  int mcount = 0;
  bit mov = 0, mun = 0;
  logic [DW-1:0] sb[$];

  sync_fifo_prog #(.DW(DW), .AW(AW), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk(clk), .resetn(resetn), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mcount));
    chk({tag, ".full"}, 32'(full), 32'(mcount == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(mcount >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(mcount <= AE));
    chk({tag, ".ovf"}, 32'(overflow), 32'(mov));
    chk({tag, ".unf"}, 32'(underflow), 32'(mun));
  endtask

  // One clock: drive inputs, predict, clock, check flags and read data.
  task automatic cyc(input string tag, input bit w, input logic [DW-1:0] wd,
                     input bit r, input bit clr);
    bit wok, rok;
    logic [DW-1:0] exp_rd;
    winc = w; wdata = wd; rinc = r; clr_err = clr;
    wok = w && (mcount < DEPTH);
    rok = r && (mcount > 0);
    exp_rd = '0;
    if (rok) exp_rd = sb.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
    if (rok) chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
`endif
    if (wok) sb.push_back(wd);
    mov = (w && mcount == DEPTH) ? 1'b1 : (clr ? 1'b0 : mov);
    mun = (r && mcount == 0)     ? 1'b1 : (clr ? 1'b0 : mun);
    mcount = mcount + int'(wok) - int'(rok);
    @(posedge clk); #1;
    winc = 0; rinc = 0; clr_err = 0;
    chk_flags(tag);
`ifndef SYNC_FIFO_FWFT_EN
    if (rok) chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
`endif
  endtask

  initial begin
    // Reset state
    #12;
    chk_flags("reset");
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset.rdata", 32'(rdata), 32'h0);
`endif
    resetn = 1'b1;

    // Fill 0x0..0xF, flags tracked every cycle
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    // Write at full: dropped, overflow sticks
    cyc("ovf", 1'b1, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drain.sb_empty", 32'(sb.size()), 32'h0);
    cyc("clr_ovf", 1'b0, '0, 1'b0, 1'b1);

    // Simultaneous read/write at count 8 across the pointer wrap
    for (int i = 0; i < 8; i++) cyc("pre8", 1'b1, DW'(i + 3), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("rw8", 1'b1, DW'(15 - i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc("post8", 1'b0, '0, 1'b1, 1'b0);

    // Underflow, clear, and set-wins-over-clear
    cyc("unf", 1'b0, '0, 1'b1, 1'b0);
    cyc("clr_unf", 1'b0, '0, 1'b0, 1'b1);
    cyc("unf_clr", 1'b0, '0, 1'b1, 1'b1);
    // Empty with winc&rinc: write taken, read dropped
    cyc("empty_rw", 1'b1, 4'h7, 1'b1, 1'b1);
    cyc("empty_rw_rd", 1'b0, '0, 1'b1, 1'b1);

    // Full with winc&rinc: read taken, write dropped
    for (int i = 0; i < DEPTH; i++) cyc("fill2", 1'b1, DW'(i ^ 5), 1'b0, 1'b0);
    cyc("full_rw", 1'b1, 4'h3, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cyc("drain2", 1'b0, '0, 1'b1, 1'b0);
    cyc("clr_all", 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-operation, asserted between edges
    for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, DW'(i + 8), 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    sb.delete(); mcount = 0; mov = 0; mun = 0;
    chk_flags("async_rst");
    @(negedge clk) resetn = 1'b1;
    #6;
    cyc("post_rst_wr", 1'b1, 4'h9, 1'b0, 1'b0);
    cyc("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end
endmodule
